// File: rtl/cpu_pkg.sv
// Shared pipeline-control types for the RV32 core: hazard controller states,
// the grouped hold/bubble control word and the x0 register index.
package cpu_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MD_BUSY  = 2'd1,
      MD_DRAIN = 2'd2
   } hazard_state_t;

   typedef struct packed {
      logic pc_hold;
      logic if_id_hold;
      logic if_id_bubble;
      logic id_ex_hold;
      logic id_ex_bubble;
      logic ex_mem_bubble;
   } pipe_ctrl_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // Control word with every hold and bubble released.
   localparam pipe_ctrl_t PIPE_IDLE = pipe_ctrl_t'(6'b000000);

endpackage

// File: rtl/hazard_detect.sv
// Load-use detector: the ID instruction reads a register that the load
// currently in EX has not yet produced. Writes to x0 never create a hazard.
module hazard_detect
   import cpu_pkg::*;
(
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_uses_rs1,
   input  logic       id_uses_rs2,
   input  logic       ex_mem_read,
   input  logic [4:0] ex_rd,
   output logic       load_use
);

   // Compare both ID source operands against the EX load destination.
   always_comb begin
      load_use = 1'b0;
      if (ex_mem_read && (ex_rd != REG_ZERO)) begin
         load_use = (id_uses_rs1 && (id_rs1 == ex_rd)) ||
                    (id_uses_rs2 && (id_rs2 == ex_rd));
      end else begin
         load_use = 1'b0;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32 core. Owns every
// stall/flush decision: load-use stalls, redirect flushes and the freeze
// while a multi-cycle mul/div runs in EX (with a timeout that aborts the op
// and raises a sticky md_error).
// Optional build macro HAZARD_PERF_CNT_EN adds stall/flush performance
// counters on ports perf_stall_cnt and perf_flush_cnt.
module hazard_ctrl
   import cpu_pkg::*;
#(
   parameter int MD_TIMEOUT = 64,
   parameter int CNT_W      = 7
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_uses_rs1,
   input  logic        id_uses_rs2,
   input  logic        ex_mem_read,
   input  logic [4:0]  ex_rd,
   input  logic        ex_redirect,
   input  logic        ex_md_op,
   input  logic        md_done,
   output logic        md_start,
   output logic        pc_hold,
   output logic        if_id_hold,
   output logic        if_id_bubble,
   output logic        id_ex_hold,
   output logic        id_ex_bubble,
   output logic        ex_mem_bubble,
`ifdef HAZARD_PERF_CNT_EN
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_flush_cnt,
`endif
   output logic        md_error
);

   // Counter value seen in the last permitted busy cycle.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

   hazard_state_t    state;
   logic [CNT_W-1:0] md_cnt;
   logic             load_use;
   logic             start_c;
   pipe_ctrl_t       ctrl;

   hazard_detect u_detect (
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_uses_rs1 (id_uses_rs1),
      .id_uses_rs2 (id_uses_rs2),
      .ex_mem_read (ex_mem_read),
      .ex_rd       (ex_rd),
      .load_use    (load_use)
   );

   // Sequencing FSM with the busy-cycle counter and the sticky timeout flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= RUN;
         md_cnt   <= {CNT_W{1'b0}};
         md_error <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (ex_md_op) begin
                  state  <= MD_BUSY;
                  md_cnt <= {CNT_W{1'b0}};
               end
            end
            MD_BUSY: begin
               md_cnt <= md_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
               if (md_done) begin
                  state <= MD_DRAIN;
               end else if (md_cnt == CNT_LAST) begin
                  md_error <= 1'b1;
                  state    <= MD_DRAIN;
               end
            end
            MD_DRAIN: begin
               state <= RUN;
            end
            default: begin
               state <= RUN;
            end
         endcase
      end
   end

   // Hold/bubble decode from the current state and this cycle's hazards.
   always_comb begin
      ctrl    = PIPE_IDLE;
      start_c = 1'b0;
      case (state)
         RUN: begin
            if (ex_md_op) begin
               // Freeze everything upstream of EX and keep EX_MEM empty.
               start_c            = 1'b1;
               ctrl.pc_hold       = 1'b1;
               ctrl.if_id_hold    = 1'b1;
               ctrl.id_ex_hold    = 1'b1;
               ctrl.ex_mem_bubble = 1'b1;
            end else if (ex_redirect) begin
               // Squash the two younger wrong-path instructions.
               ctrl.if_id_bubble = 1'b1;
               ctrl.id_ex_bubble = 1'b1;
            end else if (load_use) begin
               ctrl.pc_hold      = 1'b1;
               ctrl.if_id_hold   = 1'b1;
               ctrl.id_ex_bubble = 1'b1;
            end else begin
               ctrl = PIPE_IDLE;
            end
         end
         MD_BUSY: begin
            ctrl.pc_hold       = 1'b1;
            ctrl.if_id_hold    = 1'b1;
            ctrl.id_ex_hold    = 1'b1;
            // EX_MEM captures the result on the done cycle only.
            ctrl.ex_mem_bubble = ~md_done;
         end
         MD_DRAIN: begin
            // The finished op is still in ID_EX; do not issue it again.
            ctrl.id_ex_bubble = 1'b1;
         end
         default: begin
            ctrl = PIPE_IDLE;
         end
      endcase
   end

   assign md_start      = start_c;
   assign pc_hold       = ctrl.pc_hold;
   assign if_id_hold    = ctrl.if_id_hold;
   assign if_id_bubble  = ctrl.if_id_bubble;
   assign id_ex_hold    = ctrl.id_ex_hold;
   assign id_ex_bubble  = ctrl.id_ex_bubble;
   assign ex_mem_bubble = ctrl.ex_mem_bubble;

`ifdef HAZARD_PERF_CNT_EN
   // Free-running stall and flush event counters, wrapping at 2^32.
   always_ff @(posedge clock) begin
      if (reset) begin
         perf_stall_cnt <= 32'd0;
         perf_flush_cnt <= 32'd0;
      end else begin
         if (ctrl.pc_hold) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         end
         if (ctrl.if_id_bubble) begin
            perf_flush_cnt <= perf_flush_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus a randomized
// run checked against a cycle-level reference model of the pipeline rules.
module tb_hazard_ctrl;

   localparam int TO = 8;

   logic       clock = 1'b0;
   logic       reset;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect, ex_md_op, md_done;
   logic       md_start, pc_hold, if_id_hold, if_id_bubble, id_ex_hold, id_ex_bubble;
   logic       ex_mem_bubble, md_error;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

   int tests = 0;
   int fails = 0;

   // Reference model: where the mul/div sequence is, and the sticky error.
   bit          m_busy, m_drain, m_err;
   int          m_busy_cycles;
   int unsigned m_stall, m_flush;

   always #5 clock = ~clock;

   hazard_ctrl #(.MD_TIMEOUT(TO), .CNT_W(4)) dut (
      .clock(clock), .reset(reset),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
      .ex_redirect(ex_redirect), .ex_md_op(ex_md_op), .md_done(md_done),
      .md_start(md_start), .pc_hold(pc_hold), .if_id_hold(if_id_hold),
      .if_id_bubble(if_id_bubble), .id_ex_hold(id_ex_hold),
      .id_ex_bubble(id_ex_bubble), .ex_mem_bubble(ex_mem_bubble),
`ifdef HAZARD_PERF_CNT_EN
      .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
      .md_error(md_error)
   );

   // Observed outputs as {md_start, pc_hold, if_id_hold, if_id_bubble,
   //                      id_ex_hold, id_ex_bubble, ex_mem_bubble}.
   function automatic logic [6:0] obs();
      return {md_start, pc_hold, if_id_hold, if_id_bubble, id_ex_hold, id_ex_bubble, ex_mem_bubble};
   endfunction

   // Expected outputs from the model phase and the current inputs.
   function automatic logic [6:0] expv();
      logic       lu;
      logic [6:0] e;
      lu = ex_mem_read && (ex_rd != 5'd0) &&
           ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
      e = 7'b0000000;
      if (m_drain)          e = 7'b0000010;
      else if (m_busy)      e = {6'b011010, !md_done};
      else if (ex_md_op)    e = 7'b1110101;
      else if (ex_redirect) e = 7'b0001010;
      else if (lu)          e = 7'b0110010;
      return e;
   endfunction

   task automatic idle();
      id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
      id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
      ex_redirect = 1'b0; ex_md_op = 1'b0; md_done = 1'b0;
   endtask

   // One clock edge; the model advances with the same inputs the DUT sees.
   task automatic step();
      logic [6:0] e;
      e = expv();
      @(posedge clock);
      if (reset) begin
         m_busy = 1'b0; m_drain = 1'b0; m_err = 1'b0; m_busy_cycles = 0;
         m_stall = 0; m_flush = 0;
      end else begin
         if (e[5]) m_stall++;
         if (e[3]) m_flush++;
         if (m_drain) begin
            m_drain = 1'b0;
         end else if (m_busy) begin
            m_busy_cycles++;
            if (md_done || m_busy_cycles == TO) begin
               if (!md_done) m_err = 1'b1;
               m_busy = 1'b0;
               m_drain = 1'b1;
            end
         end else if (ex_md_op) begin
            m_busy = 1'b1;
            m_busy_cycles = 0;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; idle(); step(); step();
      reset = 1'b0; #1;
      tests++;
      if (obs() !== 7'b0000000 || md_error !== 1'b0) begin
         fails++; $display("FAIL reset: got %b/%b expected 0000000/0", obs(), md_error);
      end
`ifdef HAZARD_PERF_CNT_EN
      tests++;
      if (perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
         fails++; $display("FAIL reset_perf: got %0d/%0d expected 0/0", perf_stall_cnt, perf_flush_cnt);
      end
`endif
   endtask

   task automatic test_load_use();
      idle(); ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1; #1;
      tests++;
      if (obs() !== 7'b0110010) begin fails++; $display("FAIL load_use_rs1: got %b expected 0110010", obs()); end
      step();
      ex_mem_read = 1'b0; #1;  // load has moved on to MEM
      tests++;
      if (obs() !== 7'b0000000) begin fails++; $display("FAIL load_use_single: got %b expected 0000000", obs()); end
      ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; #1;
      tests++;
      if (obs() !== 7'b0000000) begin fails++; $display("FAIL load_use_x0: got %b expected 0000000", obs()); end
      idle(); ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_uses_rs2 = 1'b1; id_rs1 = 5'd3; #1;
      tests++;
      if (obs() !== 7'b0110010) begin fails++; $display("FAIL load_use_rs2: got %b expected 0110010", obs()); end
      id_uses_rs2 = 1'b0; #1;
      tests++;
      if (obs() !== 7'b0000000) begin fails++; $display("FAIL load_use_unused: got %b expected 0000000", obs()); end
      step(); idle();
   endtask

   task automatic test_redirect();
      idle(); ex_redirect = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1; #1;
      tests++;
      if (obs() !== 7'b0001010 || pc_hold !== 1'b0) begin
         fails++; $display("FAIL redirect_over_load_use: got %b expected 0001010", obs());
      end
      step(); idle();
      md_done = 1'b1; #1;  // stray done in RUN
      tests++;
      if (obs() !== 7'b0000000) begin fails++; $display("FAIL stray_md_done: got %b expected 0000000", obs()); end
      step(); idle();
   endtask

   task automatic test_md_latency();
      int holds = 0;
      int starts = 0;
      idle(); ex_md_op = 1'b1; ex_redirect = 1'b1; #1;
      tests++;
      if (obs() !== 7'b1110101) begin fails++; $display("FAIL md_start: got %b expected 1110101", obs()); end
      holds += pc_hold; starts += md_start;
      step(); ex_redirect = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         md_done = (i == 4); #1;
         tests++;
         if (obs() !== {6'b011010, (i != 4)}) begin
            fails++; $display("FAIL md_busy_%0d: got %b expected %b", i, obs(), {6'b011010, (i != 4)});
         end
         holds += pc_hold; starts += md_start;
         step();
      end
      md_done = 1'b0; #1;  // op still sits in EX during drain
      tests++;
      if (obs() !== 7'b0000010) begin fails++; $display("FAIL md_drain: got %b expected 0000010", obs()); end
      step(); ex_md_op = 1'b0; #1;
      tests++;
      if (obs() !== 7'b0000000 || holds != 5 || starts != 1 || md_error !== 1'b0) begin
         fails++; $display("FAIL md_sequence: got %b holds=%0d starts=%0d err=%b expected 0000000 holds=5 starts=1 err=0",
                           obs(), holds, starts, md_error);
      end
   endtask

   task automatic test_md_timeout();
      idle(); ex_md_op = 1'b1; step();
      for (int i = 1; i <= TO; i++) begin
         #1;
         tests++;
         if (obs() !== 7'b0110101 || md_error !== 1'b0) begin
            fails++; $display("FAIL md_wait_%0d: got %b/%b expected 0110101/0", i, obs(), md_error);
         end
         step();
      end
      tests++;
      if (obs() !== 7'b0000010 || md_error !== 1'b1) begin
         fails++; $display("FAIL md_timeout: got %b/%b expected 0000010/1", obs(), md_error);
      end
      step(); ex_md_op = 1'b0; #1;
      tests++;
      if (obs() !== 7'b0000000 || md_error !== 1'b1) begin
         fails++; $display("FAIL md_error_sticky: got %b/%b expected 0000000/1", obs(), md_error);
      end
   endtask

   task automatic test_reset_mid_busy();
      idle(); ex_md_op = 1'b1; step(); step();
      reset = 1'b1; step();
      reset = 1'b0; ex_md_op = 1'b0; #1;
      tests++;
      if (obs() !== 7'b0000000 || md_error !== 1'b0) begin
         fails++; $display("FAIL reset_mid_busy: got %b/%b expected 0000000/0", obs(), md_error);
      end
      step(); #1;
      tests++;
      if (obs() !== 7'b0000000) begin fails++; $display("FAIL reset_no_drain: got %b expected 0000000", obs()); end
   endtask

   task automatic test_random();
      int bad = 0;
      reset = 1'b1; idle(); step(); reset = 1'b0;
      for (int n = 0; n < 600; n++) begin
         id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
         ex_rd = 5'($urandom_range(0, 3));
         id_uses_rs1 = 1'($urandom_range(0, 1)); id_uses_rs2 = 1'($urandom_range(0, 1));
         ex_mem_read = 1'($urandom_range(0, 1));
         ex_redirect = ($urandom_range(0, 5) == 0);
         ex_md_op = m_busy ? 1'b1 : ($urandom_range(0, 7) == 0);
         md_done = m_busy ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 9) == 0);
         #1;
         tests++;
         if (obs() !== expv() || md_error !== m_err) begin
            fails++; bad++;
            if (bad <= 5) $display("FAIL random_cycle_%0d: got %b/%b expected %b/%b", n, obs(), md_error, expv(), m_err);
         end
         step();
      end
`ifdef HAZARD_PERF_CNT_EN
      tests++;
      if (perf_stall_cnt !== m_stall || perf_flush_cnt !== m_flush) begin
         fails++; $display("FAIL random_perf: got %0d/%0d expected %0d/%0d", perf_stall_cnt, perf_flush_cnt, m_stall, m_flush);
      end
`endif
   endtask

`ifdef HAZARD_PERF_CNT_EN
   task automatic test_perf();
      reset = 1'b1; idle(); step(); reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         idle(); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b1; step();
         idle(); step();
      end
      for (int i = 0; i < 2; i++) begin
         idle(); ex_redirect = 1'b1; step();
         idle(); step();
      end
      #1;
      tests++;
      if (perf_stall_cnt !== 32'd3 || perf_flush_cnt !== 32'd2) begin
         fails++; $display("FAIL perf_counts: got %0d/%0d expected 3/2", perf_stall_cnt, perf_flush_cnt);
      end
   endtask
`endif

   initial begin
      m_busy = 1'b0; m_drain = 1'b0; m_err = 1'b0; m_busy_cycles = 0;
      m_stall = 0; m_flush = 0;
      test_reset();
      test_load_use();
      test_redirect();
      test_md_latency();
      test_md_timeout();
      test_reset_mid_busy();
      test_random();
`ifdef HAZARD_PERF_CNT_EN
      test_perf();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RV32 core.
- Detects load-use hazards, taken-branch/jump redirects and multi-cycle EX (mul/div) occupancy.
- Drives hold/bubble controls for PC, IF_ID, ID_EX and EX_MEM.
- Sole owner of stall/flush decisions; pipeline registers only obey its hold/bubble inputs. A bubble loads the register's reset value ('0).

Parameters:
- MD_TIMEOUT, 64, maximum MD_BUSY cycles before forced abort with md_error.
- CNT_W, 7, width of the MD_BUSY cycle counter; must satisfy 2^CNT_W > MD_TIMEOUT.

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- id_rs1  in  5  rs1 of instruction in ID
- id_rs2  in  5  rs2 of instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  5  destination register of the EX instruction
- ex_redirect  in  1  EX resolved a taken branch/jump this cycle
- ex_md_op  in  1  EX holds a valid mul/div op
- md_done  in  1  mul/div unit result valid (1-cycle pulse)
- md_start  out  1  1-cycle start pulse to the mul/div unit
- pc_hold  out  1  PC keeps its value
- if_id_hold  out  1  IF_ID keeps its contents
- if_id_bubble  out  1  IF_ID loads '0
- id_ex_hold  out  1  ID_EX keeps its contents
- id_ex_bubble  out  1  ID_EX loads '0
- ex_mem_bubble  out  1  EX_MEM loads '0
- md_error  out  1  sticky; set on MD timeout

Behaviour:
- FSM states: RUN, MD_BUSY, MD_DRAIN. Reset: state=RUN, counter=0, md_error=0, all outputs 0.
- Outputs are combinational from state and inputs. Only the state, counter and md_error are registered.
- load_use = ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- RUN, priority order:
  1. ex_md_op: md_start=1, pc_hold=if_id_hold=id_ex_hold=1, ex_mem_bubble=1; next state MD_BUSY, counter cleared.
  2. ex_redirect: if_id_bubble=1, id_ex_bubble=1. No hold; the PC takes the redirect target.
  3. load_use: pc_hold=1, if_id_hold=1, id_ex_bubble=1. Exactly one bubble per load-use.
- ex_md_op and ex_redirect are mutually exclusive by decode. If both are asserted, ex_md_op wins and ex_redirect is ignored.
- MD_BUSY:
  - Every cycle: pc_hold, if_id_hold, id_ex_hold and ex_mem_bubble=1. md_start=0. counter increments.
  - md_done: go to MD_DRAIN. The result is captured by EX_MEM this cycle, so ex_mem_bubble=0 on the md_done cycle.
  - counter==MD_TIMEOUT-1 without md_done: set md_error, go to MD_DRAIN, keep ex_mem_bubble=1 (result discarded).
- MD_DRAIN (1 cycle):
  - id_ex_bubble=1 so the completed op is not re-issued. All holds released.
  - Next state RUN. load_use and redirect are not evaluated in this cycle.
- md_done outside MD_BUSY is ignored.
- Reset asserted mid-MD_BUSY returns to RUN next edge with no md_start. md_error clears only on reset.
- Minimum MD latency: start cycle, plus 1 busy cycle with done, plus drain = 3 cycles.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0], both reset to 0, wrapping at 2^32.
  - perf_stall_cnt increments on every cycle with pc_hold=1.
  - perf_flush_cnt increments on every cycle with if_id_bubble=1.
- Undefined: ports and counters are absent. All other behaviour is identical.

Decomposition:
- cpu_pkg gains:
  - hazard_state_t enum {RUN, MD_BUSY, MD_DRAIN};
  - pipe_ctrl_t struct grouping the hold/bubble bits;
  - REG_ZERO constant 5'd0.
- Natural sub-module: hazard_detect (pure combinational load_use compare), instantiated once.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> one cycle of pc_hold=if_id_hold=id_ex_bubble=1. Same stimulus with ex_rd=0 -> no stall.
- Redirect and load_use in the same cycle -> if_id_bubble=id_ex_bubble=1, pc_hold=0.
- ex_md_op=1, md_done 4 cycles after start -> md_start for 1 cycle; holds asserted for 5 cycles (start plus 4 busy incl. done); MD_DRAIN id_ex_bubble for 1 cycle; then back in RUN.
- md_done never arrives, MD_TIMEOUT=8 -> md_error rises after 8 busy cycles, ex_mem_bubble stays 1, state returns to RUN via MD_DRAIN.
- Reset pulsed during MD_BUSY -> next cycle all outputs 0, state RUN, md_error=0.
- With HAZARD_PERF_CNT_EN: 3 load-use stalls plus 2 redirects -> perf_stall_cnt=3, perf_flush_cnt=2.
